rtc_timer_writer: RTL

Write-side sequencer for the RTC timer registers. On a single-cycle `start`, it captures a 3-byte BCD timer value (seconds, minutes, hours) and writes each byte to the RTC over the multiplexed address/data bus: an address phase, then a data phase, per byte. It sits between the timer register bank (which supplies the values shown on VGA) and the RTC pins, and drives the bus direction the timer register does not.

---
 rtl/rtc_timer_writer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/rtc_timer_writer.sv
// Write-side sequencer for the RTC timer registers: latches seconds/minutes/hours
// and writes each byte over the multiplexed address/data bus with timed strobes.
module rtc_timer_writer #(
  parameter int unsigned T_SETUP   = 2,
  parameter int unsigned T_STROBE  = 4,
  parameter int unsigned T_HOLD    = 2,
  parameter int unsigned T_GAP     = 4,
  parameter logic [7:0]  BASE_ADDR = 8'h41
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] in_seg,
  input  logic [7:0] in_min,
  input  logic [7:0] in_hora,
  output logic [7:0] out_ad,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       a_d,
  output logic       wr_n,
  output logic       rd_n,
  output logic       busy,
  output logic       done
);

  localparam int unsigned MAX_SH  = (T_SETUP > T_HOLD) ? T_SETUP : T_HOLD;
  localparam int unsigned MAX_SG  = (T_STROBE > T_GAP) ? T_STROBE : T_GAP;
  localparam int unsigned CNT_MAX = (MAX_SH > MAX_SG) ? MAX_SH : MAX_SG;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR_SETUP,
    S_ADDR_STROBE,
    S_ADDR_HOLD,
    S_DATA_SETUP,
    S_DATA_STROBE,
    S_DATA_HOLD,
    S_GAP,
    S_DONE
  } state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [1:0]      byte_idx, byte_idx_d;
  logic            capture;
  logic [7:0]      lat_seg, lat_min, lat_hora;
  logic            in_phase, in_strobe, in_data;
  logic [7:0]      data_byte, bus_val;

  // Phase counter reload value for the state being entered
  function automatic logic [CW-1:0] load_val(input state_t s);
    logic [CW-1:0] v;
    v = '0;
    case (s)
      S_ADDR_SETUP, S_DATA_SETUP:   v = CW'(T_SETUP - 1);
      S_ADDR_STROBE, S_DATA_STROBE: v = CW'(T_STROBE - 1);
      S_ADDR_HOLD, S_DATA_HOLD:     v = CW'(T_HOLD - 1);
      S_GAP:                        v = CW'(T_GAP - 1);
      default:                      v = '0;
    endcase
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      byte_idx <= '0;
      lat_seg  <= '0;
      lat_min  <= '0;
      lat_hora <= '0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      byte_idx <= byte_idx_d;
      if (capture) begin
        lat_seg  <= in_seg;
        lat_min  <= in_min;
        lat_hora <= in_hora;
      end
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    byte_idx_d = byte_idx;
    capture    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_d    = S_ADDR_SETUP;
          byte_idx_d = '0;
          capture    = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        if (cnt != '0) begin
          cnt_d = cnt - CW'(1);
        end else begin
          case (state)
            S_ADDR_SETUP:  state_d = S_ADDR_STROBE;
            S_ADDR_STROBE: state_d = S_ADDR_HOLD;
            S_ADDR_HOLD:   state_d = S_DATA_SETUP;
            S_DATA_SETUP:  state_d = S_DATA_STROBE;
            S_DATA_STROBE: state_d = S_DATA_HOLD;
            S_DATA_HOLD:   state_d = (byte_idx < 2'd2) ? S_GAP : S_DONE;
            S_GAP: begin
              state_d    = S_ADDR_SETUP;
              byte_idx_d = byte_idx + 2'd1;
            end
            default:       state_d = S_IDLE;
          endcase
        end
      end
    endcase
    if (state_d != state) cnt_d = load_val(state_d);
  end

  always_comb begin
    in_phase  = state inside {S_ADDR_SETUP, S_ADDR_STROBE, S_ADDR_HOLD,
                              S_DATA_SETUP, S_DATA_STROBE, S_DATA_HOLD};
    in_strobe = (state == S_ADDR_STROBE) || (state == S_DATA_STROBE);
    in_data   = state inside {S_DATA_SETUP, S_DATA_STROBE, S_DATA_HOLD};
    case (byte_idx)
      2'd0:    data_byte = lat_seg;
      2'd1:    data_byte = lat_min;
      default: data_byte = lat_hora;
    endcase
    bus_val = in_data ? data_byte : BASE_ADDR + {6'd0, byte_idx};
  end

  // Pin outputs are registered from state; bus value and phase hold outside phases
  always_ff @(posedge clk) begin
    if (reset) begin
      out_ad <= '0;
      ad_oe  <= 1'b0;
      cs_n   <= 1'b1;
      a_d    <= 1'b0;
      wr_n   <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      ad_oe <= in_phase;
      cs_n  <= ~in_phase;
      wr_n  <= ~in_strobe;
      busy  <= (state != S_IDLE);
      done  <= (state == S_DONE);
      if (in_phase) begin
        out_ad <= bus_val;
        a_d    <= in_data;
      end
    end
  end

  assign rd_n = 1'b1;

endmodule
